bounce_mover: RTL
=================

BOUNCE_MOVER -- requirements
Module: bounce_mover

Interface
REQ-001 Parameter SCREEN_W, default 640, meaning visible width in pixels.
REQ-002 Parameter SCREEN_H, default 480, meaning visible height in pixels.
REQ-003 Parameter OBJ_W / OBJ_H, default 64 / 64, meaning sprite size in pixels.
REQ-004 Parameter BORDER, default 5, meaning margin; X_MIN=BORDER, X_MAX=SCREEN_W-BORDER-OBJ_W, Y_MIN=BORDER, Y_MAX=SCREEN_H-BORDER-OBJ_H.
REQ-005 Parameter X_INIT / Y_INIT, default 320 / 240, meaning reset position.
REQ-006 Parameter TICK_DIV, default 125000, meaning clk cycles per motion tick.
REQ-007 Parameter SPEED_W, default 4, meaning speed-magnitude width; SPEED_INIT default 1 for both axes.
REQ-008 Parameter COOLDOWN, default 8, meaning ticks during which collisions are ignored after a recoil.
REQ-009 Port: clk input 1 system clock.
REQ-010 Port: reset input 1 asynchronous, active-high reset.
REQ-011 Port: enable input 1, high = motion allowed, low = frozen.
REQ-012 Port: collision input 1, level, sprite overlaps an obstacle.
REQ-013 Port: load_speed input 1, one-cycle strobe latching speed_x_in/speed_y_in.
REQ-014 Port: speed_x_in / speed_y_in input SPEED_W each, unsigned magnitudes.
REQ-015 Port: x_direction / y_direction output 1 each, 1 = decreasing coordinate.
REQ-016 Port: topLeft_x / topLeft_y output 32 each, sprite top-left, unsigned.
REQ-017 Port: bounce output 1, one-cycle pulse on any wall bounce or accepted collision.
REQ-018 Port: recoil_active output 1, high while in RECOIL.

Function
REQ-019 Tick counter SHALL count 0..TICK_DIV-1 while enable=1, pulse tick when at TICK_DIV-1 and wrap to 0; hold value when enable=0.
REQ-020 States SHALL be MOVE, RECOIL, FROZEN; MOVE/RECOIL->FROZEN when enable=0; FROZEN->MOVE when enable=1 (pending cooldown discarded).
REQ-021 On tick in MOVE or RECOIL, per axis next = pos ± speed (minus when direction=1), computed in 33-bit signed.
REQ-022 If next_x <= X_MIN: topLeft_x<=X_MIN, x_direction<=0, bounce pulse; if next_x >= X_MAX: topLeft_x<=X_MAX, x_direction<=1, bounce pulse; Y identical with Y_MIN/Y_MAX.
REQ-023 Zero speed on an axis SHALL produce no motion and no bounce on that axis.
REQ-024 Collision=1 in MOVE SHALL be accepted: invert both directions, pulse bounce, load cooldown=COOLDOWN, enter RECOIL next cycle; position not changed by the collision itself.
REQ-025 In RECOIL collision SHALL be ignored; cooldown decrements per tick; at 0 return to MOVE.
REQ-026 Collision accepted on a tick cycle: direction inversion applies first, then the move uses the inverted direction; wall clamp direction overrides inversion.
REQ-027 load_speed SHALL latch magnitudes in any state, effective from the next tick; directions unchanged.
REQ-028 bounce SHALL be at most one cycle wide per event cycle; simultaneous X, Y and collision produce one pulse.
REQ-029 Positions SHALL always remain within [X_MIN,X_MAX] x [Y_MIN,Y_MAX].

Reset
REQ-030 reset=1 SHALL immediately force topLeft_x=X_INIT, topLeft_y=Y_INIT, directions=0, speeds=SPEED_INIT, counter=0, cooldown=0, state=MOVE, bounce=0, recoil_active=0.
REQ-031 Reset mid-RECOIL SHALL clear cooldown; first tick after release occurs TICK_DIV cycles later.

Configuration
REQ-032 Macro BOUNCE_MOVER_WRAP_EN defined: X axis wraps instead of bouncing (next_x > X_MAX -> X_MIN, next_x < X_MIN -> X_MAX, x_direction unchanged, no bounce pulse); Y axis unchanged.
REQ-033 Macro BOUNCE_MOVER_WRAP_EN undefined: X axis bounces per REQ-022.

Verification (TICK_DIV=4, COOLDOWN=2)
REQ-034 Reset release, enable=1, 8 cycles -> topLeft=(322,242), ticks at cycles 4 and 8.
REQ-035 Force position X=570 dir 0, speed_x 3 -> next tick topLeft_x=571 (X_MAX), x_direction=1, bounce one cycle.
REQ-036 collision held 20 cycles from MOVE -> one bounce, directions inverted once, recoil_active high for 2 ticks, then second collision accepted.
REQ-037 enable=0 for 10 cycles mid-count -> position and counter frozen; resumes exact count on enable=1.
REQ-038 WRAP_EN build, X=7 dir 1 speed 4 -> topLeft_x=571, x_direction=1, no bounce.
REQ-039 reset asserted mid-RECOIL -> all outputs at reset values same cycle, recoil_active=0.

Source files
------------

// File: rtl/bounce_mover_if.sv
// Bounce mover control/status bundle: motion controls in, sprite position and status out.
interface bounce_mover_if #(
    parameter int unsigned SPEED_W = 4
);
    logic               enable;
    logic               collision;
    logic               load_speed;
    logic [SPEED_W-1:0] speed_x_in;
    logic [SPEED_W-1:0] speed_y_in;
    logic               x_direction;
    logic               y_direction;
    logic [31:0]        topLeft_x;
    logic [31:0]        topLeft_y;
    logic               bounce;
    logic               recoil_active;

    // Driver side (stimulus / upstream controller)
    modport master (
        output enable, collision, load_speed, speed_x_in, speed_y_in,
        input  x_direction, y_direction, topLeft_x, topLeft_y, bounce, recoil_active
    );

    // Mover side
    modport slave (
        input  enable, collision, load_speed, speed_x_in, speed_y_in,
        output x_direction, y_direction, topLeft_x, topLeft_y, bounce, recoil_active
    );
endinterface

// File: rtl/bounce_mover.sv
// Bounce mover: moves a sprite's top-left corner across the screen once per motion
// tick, bouncing off the border walls and recoiling from obstacle collisions.
// Optional build macro BOUNCE_MOVER_WRAP_EN: X axis wraps around instead of bouncing.
module bounce_mover #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned OBJ_W      = 64,
    parameter int unsigned OBJ_H      = 64,
    parameter int unsigned BORDER     = 5,
    parameter int unsigned X_INIT     = 320,
    parameter int unsigned Y_INIT     = 240,
    parameter int unsigned TICK_DIV   = 125000,
    parameter int unsigned SPEED_W    = 4,
    parameter int unsigned SPEED_INIT = 1,
    parameter int unsigned COOLDOWN   = 8
) (
    input  logic            clk,
    input  logic            reset,
    bounce_mover_if.slave   bus
);

    localparam int unsigned X_MIN = BORDER;
    localparam int unsigned X_MAX = SCREEN_W - BORDER - OBJ_W;
    localparam int unsigned Y_MIN = BORDER;
    localparam int unsigned Y_MAX = SCREEN_H - BORDER - OBJ_H;
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic signed [32:0] X_MIN_S = 33'(X_MIN);
    localparam logic signed [32:0] X_MAX_S = 33'(X_MAX);
    localparam logic signed [32:0] Y_MIN_S = 33'(Y_MIN);
    localparam logic signed [32:0] Y_MAX_S = 33'(Y_MAX);

    typedef enum logic [1:0] {
        MOVE   = 2'd0,
        RECOIL = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CD_W-1:0]    cd_q;
    logic [SPEED_W-1:0] spx_q, spy_q;
    logic [31:0]        x_q, x_d, y_q, y_d;
    logic               xdir_q, xdir_d, ydir_q, ydir_d;
    logic               bounce_q, bounce_d;
    logic               recoil_q;

    logic               tick;
    logic               coll_acc;
    logic               xdir_eff, ydir_eff;
    logic               x_hit, y_hit;
    logic signed [32:0] nx, ny;

    // Motion tick prescaler; frozen together with the rest of the mover when disabled
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (bus.enable) begin
            if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Tick counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Collision acceptance and effective directions; a FROZEN mover that is being
    // re-enabled behaves as MOVE this cycle so that no tick is lost on resume
    always_comb begin
        coll_acc = bus.enable && bus.collision && (state_q != RECOIL);
        xdir_eff = coll_acc ? ~xdir_q : xdir_q;
        ydir_eff = coll_acc ? ~ydir_q : ydir_q;
    end

    // Candidate positions, 33-bit signed so underflow below zero is visible
    always_comb begin
        nx = xdir_eff ? ($signed({1'b0, x_q}) - $signed(33'(spx_q)))
                      : ($signed({1'b0, x_q}) + $signed(33'(spx_q)));
        ny = ydir_eff ? ($signed({1'b0, y_q}) - $signed(33'(spy_q)))
                      : ($signed({1'b0, y_q}) + $signed(33'(spy_q)));
    end

    // X axis next state: bounce off walls (or wrap), wall clamp wins over inversion
    always_comb begin
        x_d    = x_q;
        xdir_d = xdir_eff;
        x_hit  = 1'b0;
        if (tick && (spx_q != '0)) begin
`ifdef BOUNCE_MOVER_WRAP_EN
            if (nx > X_MAX_S) begin
                x_d = 32'(X_MIN);
            end else if (nx < X_MIN_S) begin
                x_d = 32'(X_MAX);
            end else begin
                x_d = nx[31:0];
            end
`else
            if (nx <= X_MIN_S) begin
                x_d    = 32'(X_MIN);
                xdir_d = 1'b0;
                x_hit  = 1'b1;
            end else if (nx >= X_MAX_S) begin
                x_d    = 32'(X_MAX);
                xdir_d = 1'b1;
                x_hit  = 1'b1;
            end else begin
                x_d = nx[31:0];
            end
`endif
        end
    end

    // Y axis next state: always bounces off walls
    always_comb begin
        y_d    = y_q;
        ydir_d = ydir_eff;
        y_hit  = 1'b0;
        if (tick && (spy_q != '0)) begin
            if (ny <= Y_MIN_S) begin
                y_d    = 32'(Y_MIN);
                ydir_d = 1'b0;
                y_hit  = 1'b1;
            end else if (ny >= Y_MAX_S) begin
                y_d    = 32'(Y_MAX);
                ydir_d = 1'b1;
                y_hit  = 1'b1;
            end else begin
                y_d = ny[31:0];
            end
        end
    end

    // Any wall hit or accepted collision in a cycle collapses into one pulse
    always_comb begin
        bounce_d = x_hit | y_hit | coll_acc;
    end

    // Mode FSM with registered position, direction, speed and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MOVE;
            cd_q     <= '0;
            spx_q    <= SPEED_W'(SPEED_INIT);
            spy_q    <= SPEED_W'(SPEED_INIT);
            x_q      <= 32'(X_INIT);
            y_q      <= 32'(Y_INIT);
            xdir_q   <= 1'b0;
            ydir_q   <= 1'b0;
            bounce_q <= 1'b0;
            recoil_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            xdir_q   <= xdir_d;
            ydir_q   <= ydir_d;
            bounce_q <= bounce_d;
            if (bus.load_speed) begin
                spx_q <= bus.speed_x_in;
                spy_q <= bus.speed_y_in;
            end
            case (state_q)
                MOVE: begin
                    if (!bus.enable) begin
                        state_q <= FROZEN;
                    end else if (coll_acc) begin
                        state_q  <= RECOIL;
                        cd_q     <= CD_W'(COOLDOWN);
                        recoil_q <= 1'b1;
                    end
                end
                RECOIL: begin
                    if (!bus.enable) begin
                        state_q  <= FROZEN;
                        cd_q     <= '0;
                        recoil_q <= 1'b0;
                    end else if (cd_q == '0) begin
                        state_q  <= MOVE;
                        recoil_q <= 1'b0;
                    end else if (tick) begin
                        cd_q <= cd_q - CD_W'(1);
                        if (cd_q == CD_W'(1)) begin
                            state_q  <= MOVE;
                            recoil_q <= 1'b0;
                        end
                    end
                end
                FROZEN: begin
                    cd_q <= '0;
                    if (bus.enable) begin
                        if (coll_acc) begin
                            state_q  <= RECOIL;
                            cd_q     <= CD_W'(COOLDOWN);
                            recoil_q <= 1'b1;
                        end else begin
                            state_q <= MOVE;
                        end
                    end
                end
                default: begin
                    state_q  <= MOVE;
                    cd_q     <= '0;
                    recoil_q <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bus from the output registers
    assign bus.topLeft_x     = x_q;
    assign bus.topLeft_y     = y_q;
    assign bus.x_direction   = xdir_q;
    assign bus.y_direction   = ydir_q;
    assign bus.bounce        = bounce_q;
    assign bus.recoil_active = recoil_q;

endmodule
